// File: rtl/fp_absmin_reduce.sv
// Streams frames of IEEE-754 elements and reports the element of minimum (or maximum) magnitude with its frame index.
// Result appears one cycle after the last beat; input stalls while the result waits for m_ready.
module fp_absmin_reduce #(
    parameter int DATA_W   = 32,
    parameter int LANES    = 4,
    parameter int IDX_W    = 16,
    parameter int FIND_MAX = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [LANES*DATA_W-1:0]   s_data,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic [IDX_W-1:0]          m_idx
);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    localparam logic [IDX_W-1:0] LANES_W = IDX_W'(LANES);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  acc_dat_q, acc_dat_d;
    logic [IDX_W-1:0]   acc_idx_q, acc_idx_d;
    logic [IDX_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               live_q;

    logic [IDX_W-1:0]   base_idx;
    logic [DATA_W-1:0]  lane_dat;
    logic [DATA_W-1:0]  win_dat;
    logic [IDX_W-1:0]   win_idx;

    // Strict comparison: ties always keep the incumbent (lower index).
    function automatic logic better(input logic [DATA_W-2:0] cand, input logic [DATA_W-2:0] inc);
        if (FIND_MAX != 0) return cand > inc;
        else               return cand < inc;
    endfunction

    assign base_idx = beat_cnt_q * LANES_W;

    always_comb begin
        lane_dat = '0;
        win_dat  = s_data[0 +: DATA_W];
        win_idx  = base_idx;
        for (int k = 1; k < LANES; k++) begin
            lane_dat = s_data[k*DATA_W +: DATA_W];
            if (better(lane_dat[DATA_W-2:0], win_dat[DATA_W-2:0])) begin
                win_dat = lane_dat;
                win_idx = base_idx + IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_dat_d  = acc_dat_q;
        acc_idx_d  = acc_idx_q;
        beat_cnt_d = beat_cnt_q;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                // Held low until the first edge after reset release.
                s_ready = live_q;
                if (s_valid && live_q) begin
                    acc_dat_d  = win_dat;
                    acc_idx_d  = win_idx;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    state_d    = s_last ? OUT : ACC;
                end
            end
            ACC: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (better(win_dat[DATA_W-2:0], acc_dat_q[DATA_W-2:0])) begin
                        acc_dat_d = win_dat;
                        acc_idx_d = win_idx;
                    end
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (s_last) state_d = OUT;
                end
            end
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d    = IDLE;
                    acc_dat_d  = '0;
                    acc_idx_d  = '0;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_data = acc_dat_q;
    assign m_idx  = acc_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_dat_q  <= '0;
            acc_idx_q  <= '0;
            beat_cnt_q <= '0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_dat_q  <= acc_dat_d;
            acc_idx_q  <= acc_idx_d;
            beat_cnt_q <= beat_cnt_d;
            live_q     <= 1'b1;
        end
    end

endmodule

// File: doc/fp_absmin_reduce.md
FP_ABSMIN_REDUCE -- requirements
Module: fp_absmin_reduce

Interface
REQ-001 SHALL have parameter DATA_W, default 32: element width, IEEE-754 layout with sign at bit DATA_W-1.
REQ-002 SHALL have parameter LANES, default 4, legal values 1..16: elements per input beat.
REQ-003 SHALL have parameter IDX_W, default 16: width of the result index.
REQ-004 SHALL have parameter FIND_MAX, default 0: 0 selects the minimum magnitude, 1 selects the maximum magnitude.
REQ-005 SHALL use one clock and an asynchronous, active-low reset (clk, rst_n); polarity and synchronicity are fixed.
REQ-006 SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock; all state changes on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- s_valid, in, 1, input beat valid.
- s_ready, out, 1, input beat accepted when s_valid and s_ready are both high.
- s_data, in, LANES*DATA_W, lane k occupies bits [k*DATA_W +: DATA_W].
- s_last, in, 1, marks the final beat of a frame.
- m_valid, out, 1, result valid.
- m_ready, in, 1, result consumed when m_valid and m_ready are both high.
- m_data, out, DATA_W, winning element, original bits including sign.
- m_idx, out, IDX_W, frame-relative index of the winning element.

Function
REQ-007 Magnitude SHALL be the unsigned value of bits [DATA_W-2:0]; the sign bit is ignored for comparison only.
REQ-008 A candidate SHALL replace the incumbent only if its magnitude is strictly smaller (FIND_MAX=0) or strictly larger (FIND_MAX=1).
- On equal magnitudes the lower index wins; +0 and -0 are equal.
REQ-009 NaN and Inf SHALL get no special handling; the raw-bit ordering of REQ-007 applies.
REQ-010 Element index SHALL be beat_cnt*LANES + lane, computed modulo 2^IDX_W; beat_cnt counts accepted beats from 0 within the frame.
REQ-011 SHALL implement a state machine with three states:
- IDLE: no frame in progress.
- ACC: frame in progress, accumulator holds the best element so far.
- OUT: result held on the output.
REQ-012 State transitions on an accepted beat SHALL be:
- IDLE with s_last=0 goes to ACC; accumulator loads the beat winner.
- IDLE with s_last=1 goes to OUT (single-beat frame).
- ACC with s_last=0 stays in ACC; accumulator merges the beat winner with the incumbent, incumbent winning ties.
- ACC with s_last=1 goes to OUT with the merged result.
REQ-013 In OUT, the transition SHALL be to IDLE on m_ready; beat_cnt and the accumulator clear.
REQ-014 s_ready SHALL be 1 in IDLE and ACC and 0 in OUT.
- A beat arriving during OUT stalls; it is not dropped.
REQ-015 m_valid SHALL be 1 exactly in OUT.
- m_valid asserts on the cycle after the s_last beat is accepted (latency 1).
- m_data and m_idx SHALL stay stable while m_valid=1 and m_ready=0.
REQ-016 A new frame SHALL be acceptable on the cycle after the result handshake; throughput is one frame per (beats+1) cycles at minimum.
REQ-017 The lane winner within a beat SHALL be computed combinationally, lowest lane winning ties, and registered only into the accumulator or output.
REQ-018 beat_cnt SHALL wrap silently at 2^IDX_W; no error is flagged.
REQ-019 s_data and s_last SHALL be ignored when s_valid=0; m_ready SHALL be ignored outside OUT.

Reset
REQ-020 While rst_n=0, outputs SHALL be: s_ready=0, m_valid=0, m_data=0, m_idx=0; state=IDLE, beat_cnt=0, accumulator=0.
REQ-021 Assertion of rst_n SHALL abort any frame or pending result immediately with no output.
- s_ready SHALL rise on the first clock edge after deassertion.

Verification
REQ-022 The bench SHALL cover these directed scenarios (LANES=4, FIND_MAX=0 unless stated):
- Single beat {3.0, -1.5, 2.0, 8.0}, s_last=1: one cycle later m_valid=1, m_data=0xBFC00000, m_idx=1.
- Three beats; -0.25 in beat 2 lane 3, all other elements 1.0: m_data=0xBE800000, m_idx=11.
- Ties, elements {+0, -0, 5, 5}: m_data=0x00000000, m_idx=0. With FIND_MAX=1 and {1, 5, -5, 2}: m_data=0x40A00000, m_idx=1.
- Backpressure: m_ready held low for 5 cycles with s_valid=1: s_ready=0 and m_data/m_idx stable throughout; the next frame is accepted the cycle after the handshake.
- Reset mid-frame after 2 beats: no m_valid; a following 1-beat frame reports an index counted from 0.
- NaN 0x7FC00000 in lane 0, other lanes 1.0, FIND_MAX=0: m_idx=1.
